muldiv_unit: RTL and testbench

//   Execute-stage companion to the ALU: multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO register pair.
//   Fed the same rs/rt operands as the ALU. Drives busy so hazard logic stalls the pipe; HI/LO feed MFHI/MFLO forwarding.

---
 rtl/muldiv_unit_pkg.sv | 26 ++
 rtl/muldiv_unit_div_core.sv | 60 ++++++
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op codes and state encodings for the mul/div unit
// Purpose : md_op codes driven by the decoder, FSM state encoding and the
//           nominal division step count.
// Ports   : none (package).
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

  // One restoring step per operand bit at the default 32-bit width.
  localparam int DIV_STEPS = 32;

endpackage

// File: rtl/muldiv_unit_div_core.sv
// rtl/muldiv_unit_div_core.sv - unsigned iterative restoring divider, one quotient bit per step
// Purpose : Holds the partial remainder, the dividend/quotient shift register
//           and the divisor. After WIDTH steps following a load, quotient and
//           remainder hold the unsigned result (undefined for divisor 0).
// Ports   : clk       in  clock, rising edge
//           rst       in  synchronous active-high reset
//           load      in  capture dividend/divisor, clear partial remainder
//           dividend  in  WIDTH unsigned dividend
//           divisor   in  WIDTH unsigned divisor
//           step      in  perform one restoring step
//           quotient  out WIDTH quotient
//           remainder out WIDTH remainder
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // The dividend shifts out of the top of quo_q while quotient bits shift in
  // at the bottom, so one register serves both.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      // trial[WIDTH] set means the subtraction went negative: restore.
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
      end else begin
        rem_q <= shifted[WIDTH-1:0];
      end
      quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO pair
// Purpose : Execute-stage companion to the ALU. Multiply takes two edges,
//           divide takes WIDTH+2 edges; busy stalls the pipe, done pulses when
//           HI/LO were written by a MULT/DIV. MTHI/MTLO write in a single edge.
// Config  : MULDIV_FLUSH_EN adds the flush port, which aborts an in-flight op
//           and suppresses a same-cycle start.
// Ports   : clk   in  clock, rising edge
//           rst   in  synchronous active-high reset
//           start in  issue request, sampled only in IDLE
//           op    in  md_op code
//           a     in  rs operand (dividend / multiplicand / MT source)
//           b     in  rt operand (divisor / multiplier)
//           flush in  abort (only with MULDIV_FLUSH_EN)
//           busy  out high while a MULT/DIV is in flight
//           done  out one-cycle pulse after the MULT/DIV result write
//           hi    out HI register
//           lo    out LO register
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_FLUSH_EN
  input  logic             flush,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_e        state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mul_signed_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div_zero_q;

  logic             kill;
  logic             is_div_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             div_load;
  logic             div_step;
  logic [WIDTH-1:0] quo_raw;
  logic [WIDTH-1:0] rem_raw;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product_d;

`ifdef MULDIV_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // Operand magnitudes for the unsigned core; DIVU passes raw values.
  assign is_div_op = (op == MD_DIV) || (op == MD_DIVU);
  assign a_neg     = (op == MD_DIV) && a[WIDTH-1];
  assign b_neg     = (op == MD_DIV) && b[WIDTH-1];
  assign a_abs     = a_neg ? (~a + 1'b1) : a;
  assign b_abs     = b_neg ? (~b + 1'b1) : b;

  assign div_load  = (state_q == S_IDLE) && start && is_div_op && !kill;
  assign div_step  = (state_q == S_DIV) && !kill;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .step      (div_step),
    .quotient  (quo_raw),
    .remainder (rem_raw)
  );

  // Quotient negates on differing signs; remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
  assign quo_fix_d = neg_quo_q ? (~quo_raw + 1'b1) : quo_raw;
  assign rem_fix_d = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;

  // Extending both operands to 2*WIDTH makes the low half of one product
  // correct for signed and unsigned alike.
  assign a_ext     = mul_signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext     = mul_signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign product_d = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        // Abort wins over any pending write or new issue.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              case (op)
                MD_MULT, MD_MULTU: begin
                  a_q          <= a;
                  b_q          <= b;
                  mul_signed_q <= (op == MD_MULT);
                  state_q      <= S_MUL;
                  busy_q       <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                  a_q        <= a;
                  b_q        <= b;
                  neg_quo_q  <= a_neg ^ b_neg;
                  neg_rem_q  <= a_neg;
                  div_zero_q <= (b == '0);
                  cnt_q      <= '0;
                  state_q    <= S_DIV;
                  busy_q     <= 1'b1;
                end
                MD_MTHI: hi_q <= a;
                MD_MTLO: lo_q <= a;
                default: ;
              endcase
            end
          end
          S_MUL: begin
            {hi_q, lo_q} <= product_d;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
          S_DIV: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              state_q <= S_FIX;
            end
          end
          S_FIX: begin
            if (div_zero_q) begin
              lo_q <= '1;
              hi_q <= a_q;
            end else begin
              lo_q <= quo_fix_d;
              hi_q <= rem_fix_d;
            end
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef MULDIV_FLUSH_EN
    .flush (flush),
`endif
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int     ix, iy, q, r;
    logic [63:0] ux, uy;
    ref_result = '0;
    case (o)
      MD_MULT: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ref_result = 64'(sx * sy);
      end
      MD_MULTU: begin
        ux = {32'd0, x};
        uy = {32'd0, y};
        ref_result = ux * uy;
      end
      MD_DIVU: begin
        if (y == 0) ref_result = {x, 32'hFFFFFFFF};
        else        ref_result = {x % y, x / y};
      end
      MD_DIV: begin
        if (y == 0) ref_result = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) ref_result = {32'd0, 32'h80000000};
        else begin
          ix = x;
          iy = y;
          q  = ix / iy;
          r  = ix % iy;
          ref_result = {32'(r), 32'(q)};
        end
      end
      default: ref_result = '0;
    endcase
  endfunction

  // Latency-count model: an accepted MULT writes one edge after issue, a DIV 33 edges after.
  bit          m_valid = 0;
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_valid) begin
      m_done = 0;
      if (flush) begin
        m_busy = 0;
        m_left = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_busy = 0; m_done = 1;
        end
      end else if (start) begin
        case (op)
          MD_MULT, MD_MULTU: begin
            {p_hi, p_lo} = ref_result(op, a, b); m_busy = 1; m_left = 1;
          end
          MD_DIV, MD_DIVU: begin
            {p_hi, p_lo} = ref_result(op, a, b); m_busy = 1; m_left = 33;
          end
          MD_MTHI: m_hi = a;
          MD_MTLO: m_lo = a;
          default: ;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_hi",   64'(hi),   64'(m_hi));
      chk("cyc_lo",   64'(lo),   64'(m_lo));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Edges after E0 until done is seen.
  task automatic wait_done(output int lat);
    bit found = 0;
    lat = -1;
    for (int k = 1; k <= 60 && !found; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; found = 1; end
    end
    if (!found) begin
      n_total++;
      $display("FAIL wait_done: got no done expected done within 60 edges");
    end
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    int lat;
    vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[7] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8] = '{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};

    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi",   64'(hi),   64'd0);
    chk("reset_lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Each issue lands in the done cycle of the previous one (back-to-back).
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat),
          (vecs[i].op == MD_MULT || vecs[i].op == MD_MULTU) ? 64'd1 : 64'd33);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);

    issue(MD_MTHI, 32'h1234, 32'd0);
    chk("mthi_hi",   64'(hi),   64'h1234);
    chk("mthi_lo",   64'(lo),   64'hFFFFFFFF);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    issue(MD_MTLO, 32'h5678, 32'd0);
    chk("mtlo_hi", 64'(hi), 64'h1234);
    chk("mtlo_lo", 64'(lo), 64'h5678);
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    chk("unk_busy", 64'(busy), 64'd0);
    chk("unk_hi",   64'(hi),   64'h1234);

    // MULT issued while DIV busy must be ignored: 1000 / -3 = -333 rem 1.
    issue(MD_DIV, 32'd1000, 32'hFFFFFFFD);
    start = 1'b1; op = MD_MULT; a = 32'd7; b = 32'd9;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("busy_ign_lo", 64'(lo), 64'hFFFFFEB3);
    chk("busy_ign_hi", 64'(hi), 64'd1);
    @(posedge clk); #1;
    chk("busy_ign_idle", 64'(busy), 64'd0);

    // Reset sampled at E10 of a DIV.
    issue(MD_DIV, 32'd77, 32'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi",   64'(hi),   64'd0);
    chk("midrst_lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(MD_DIVU, 32'hFFFFFFFF, 32'h10);
    wait_done(lat);
    chk("postrst_lat", 64'(lat), 64'd33);
    chk("postrst_lo",  64'(lo),  64'h0FFFFFFF);
    chk("postrst_hi",  64'(hi),  64'hF);

`ifdef MULDIV_FLUSH_EN
    issue(MD_MTHI, 32'hA, 32'd0);
    issue(MD_MTLO, 32'hB, 32'd0);
    issue(MD_DIV, 32'd50, 32'd3);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", 64'(busy), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hi",   64'(hi),   64'hA);
    chk("flush_lo",   64'(lo),   64'hB);
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; a = 32'h55; flush = 1'b1;
    @(negedge clk);
    op = MD_DIV; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_hi",   64'(hi),   64'hA);
    chk("flush_start_busy", 64'(busy), 64'd0);
`endif

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
